// File: rtl/shared_op_scheduler.sv
// shared_op_scheduler
//
// Shares one arithmetic operator (add, sub or mul, chosen by the op
// parameter) between num_ch pull-handshake input channels. Channels are
// visited round-robin. Each visit pulls one operand pair, runs it through
// the operator for `latency` cycles, and offers the result, tagged with
// its source channel, on a single pull-handshake output. At most one
// operation is in flight at a time.
//
// Ports
//   clk      : clock
//   rst      : synchronous, active-high reset
//   in_req   : per-channel pull request (one-hot or zero), registered
//   in_ack   : per-channel one-cycle data-valid pulse
//   in_data  : per-channel operands; channel i is [2W(i+1)-1 : 2Wi],
//              operand a is the low half and operand b is the high half
//   out_req  : downstream pull request
//   out_ack  : one-cycle result-valid pulse, registered
//   out_data : result, held until the next out_ack
//   out_id   : source channel of out_data, held with it
//   busy     : high in every state except FETCH
//
// state   | meaning
// --------+------------------------------------------------------------
// s_fetch | request from channel ptr; wait for its ack or the timeout
// s_drain | one cycle to catch an ack issued from a registered req
// s_exec  | operator running; counts down latency cycles
// s_send  | result ready; waits for out_req
module shared_op_scheduler #(
    parameter int    data_width    = 32,
    parameter int    num_ch        = 4,
    parameter int    id_width      = 2,
    parameter string op            = "add",
    parameter int    latency       = 2,
    parameter int    fetch_timeout = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [num_ch-1:0]              in_req,
    input  logic [num_ch-1:0]              in_ack,
    input  logic [num_ch*2*data_width-1:0] in_data,
    input  logic                           out_req,
    output logic                           out_ack,
    output logic [data_width-1:0]          out_data,
    output logic [id_width-1:0]            out_id,
    output logic                           busy
);

    localparam int op_sel = (op == "mul") ? 2 : ((op == "sub") ? 1 : 0);
    localparam int wait_w = (fetch_timeout > 1) ? $clog2(fetch_timeout) : 1;
    localparam logic [wait_w-1:0] wait_last =
        wait_w'((fetch_timeout > 0) ? fetch_timeout - 1 : 0);
    localparam logic [3:0] exec_load = 4'(latency - 1);
    localparam logic [id_width-1:0] last_ch = id_width'(num_ch - 1);
    localparam logic timeout_en = (fetch_timeout != 0);

    typedef enum logic [1:0] {
        s_fetch,
        s_drain,
        s_exec,
        s_send
    } state_t;

    state_t                  state_q, state_d;
    logic [id_width-1:0]     ptr_q, ptr_d;
    logic [id_width-1:0]     tag_q, tag_d;
    logic [wait_w-1:0]       wait_q, wait_d;
    logic [3:0]              exec_q, exec_d;
    logic [data_width-1:0]   a_q, a_d;
    logic [data_width-1:0]   b_q, b_d;
    logic [data_width-1:0]   res_q, res_d;
    logic [num_ch-1:0]       in_req_q, in_req_d;
    logic                    out_ack_q, out_ack_d;
    logic [data_width-1:0]   out_data_q, out_data_d;
    logic [id_width-1:0]     out_id_q, out_id_d;

    logic                    ack_sel;
    logic [2*data_width-1:0] sel_word;
    logic [num_ch-1:0]       ptr_onehot;
    logic [data_width-1:0]   op_result;
    logic [id_width-1:0]     ptr_inc;
    logic [id_width-1:0]     tag_inc;

    // Only the channel under the pointer is looked at; acks elsewhere are
    // simply never selected.
    always_comb begin
        ack_sel    = 1'b0;
        sel_word   = '0;
        ptr_onehot = '0;
        for (int i = 0; i < num_ch; i++) begin
            if (ptr_q == id_width'(i)) begin
                ack_sel       = in_ack[i];
                sel_word      = in_data[i*2*data_width +: 2*data_width];
                ptr_onehot[i] = 1'b1;
            end
        end
    end

    // All three operations wrap to data_width bits by assignment width.
    always_comb begin
        case (op_sel)
            1:       op_result = a_q - b_q;
            2:       op_result = a_q * b_q;
            default: op_result = a_q + b_q;
        endcase
    end

    assign ptr_inc = (ptr_q == last_ch) ? '0 : ptr_q + 1'b1;
    assign tag_inc = (tag_q == last_ch) ? '0 : tag_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= s_fetch;
            ptr_q      <= '0;
            tag_q      <= '0;
            wait_q     <= '0;
            exec_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            in_req_q   <= '0;
            out_ack_q  <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tag_q      <= tag_d;
            wait_q     <= wait_d;
            exec_q     <= exec_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            in_req_q   <= in_req_d;
            out_ack_q  <= out_ack_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tag_d      = tag_q;
        wait_d     = '0;
        exec_d     = exec_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        in_req_d   = '0;
        out_ack_d  = 1'b0;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;

        case (state_q)
            s_fetch: begin
                // The ack is checked before the timeout so it wins a tie.
                if (ack_sel) begin
                    a_d     = sel_word[data_width-1:0];
                    b_d     = sel_word[2*data_width-1:data_width];
                    tag_d   = ptr_q;
                    exec_d  = exec_load;
                    state_d = s_exec;
                end else if (timeout_en && wait_q == wait_last) begin
                    state_d = s_drain;
                end else begin
                    wait_d   = wait_q + 1'b1;
                    in_req_d = ptr_onehot;
                end
            end
            s_drain: begin
                if (ack_sel) begin
                    a_d     = sel_word[data_width-1:0];
                    b_d     = sel_word[2*data_width-1:data_width];
                    tag_d   = ptr_q;
                    exec_d  = exec_load;
                    state_d = s_exec;
                end else begin
                    ptr_d   = ptr_inc;
                    state_d = s_fetch;
                end
            end
            s_exec: begin
                if (exec_q == 4'd0) begin
                    res_d   = op_result;
                    state_d = s_send;
                end else begin
                    exec_d = exec_q - 4'd1;
                end
            end
            s_send: begin
                if (out_req && !out_ack_q) begin
                    out_ack_d  = 1'b1;
                    out_data_d = res_q;
                    out_id_d   = tag_q;
                    ptr_d      = tag_inc;
                    state_d    = s_fetch;
                end
            end
            default: state_d = s_fetch;
        endcase
    end

    assign in_req   = in_req_q;
    assign out_ack  = out_ack_q;
    assign out_data = out_data_q;
    assign out_id   = out_id_q;
    assign busy     = (state_q != s_fetch);

endmodule

// File: tb/tb_shared_op_scheduler.sv
// Bench for shared_op_scheduler: three instances (add, sub, mul) share one
// set of producers and one downstream out_req. An event-time model predicts
// every output each cycle; directed sections pin timing and values by hand.
module tb_shared_op_scheduler;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int L  = 2;
    localparam int T  = 8;

    localparam int READY  = 0;  // acks while its req is high
    localparam int SILENT = 1;  // never acks
    localparam int LATE   = 2;  // acks the cycle after its req falls
    localparam int SPAM   = 3;  // acks every cycle

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_ack = '0;
    logic [N*2*W-1:0] in_data;
    logic           out_req = 1'b1;

    logic [N-1:0]   req_o  [3];
    logic           ack_o  [3];
    logic [W-1:0]   data_o [3];
    logic [IW-1:0]  id_o   [3];
    logic           busy_o [3];

    int             mode [N];
    logic [W-1:0]   opa  [N];
    logic [W-1:0]   opb  [N];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) begin
            in_data[i*2*W +: W]     = opa[i];
            in_data[i*2*W + W +: W] = opb[i];
        end
    end

    shared_op_scheduler #(.data_width(W), .num_ch(N), .id_width(IW), .op("add"),
                          .latency(L), .fetch_timeout(T)) dut_add (
        .clk(clk), .rst(rst), .in_req(req_o[0]), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(ack_o[0]), .out_data(data_o[0]), .out_id(id_o[0]),
        .busy(busy_o[0]));

    shared_op_scheduler #(.data_width(W), .num_ch(N), .id_width(IW), .op("sub"),
                          .latency(L), .fetch_timeout(T)) dut_sub (
        .clk(clk), .rst(rst), .in_req(req_o[1]), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(ack_o[1]), .out_data(data_o[1]), .out_id(id_o[1]),
        .busy(busy_o[1]));

    shared_op_scheduler #(.data_width(W), .num_ch(N), .id_width(IW), .op("mul"),
                          .latency(L), .fetch_timeout(T)) dut_mul (
        .clk(clk), .rst(rst), .in_req(req_o[2]), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(ack_o[2]), .out_data(data_o[2]), .out_id(id_o[2]),
        .busy(busy_o[2]));

    function automatic int now_cyc();
        return int'($time / 10);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, now_cyc(), act, exp);
        end
    endtask

    // ---------------- model + producers, evaluated once per cycle ----------
    // The model works in event times: m_fs is the cycle the current channel
    // started being offered, k counts cycles since then; an accepted pair
    // becomes sendable latency+1 cycles after its ack.
    bit           rst_prev = 1'b0;
    bit           m_valid  = 1'b0;
    bit           m_inflight;
    int           m_ptr, m_fs, m_tag, m_send_ready, m_fire;
    logic [W-1:0] m_res [3];
    logic [W-1:0] m_out [3];
    int           m_out_id;
    logic [N-1:0] prev_req = '0;
    int           ack0_t = -1;

    initial begin
        forever begin
            int           cyc, k;
            bit           fired;
            logic [N-1:0] exp_req;
            bit           exp_busy, take;
            int           md;
            @(negedge clk);
            cyc   = now_cyc();
            fired = 1'b0;
            if (rst_prev) begin
                m_valid    = 1'b1;
                m_inflight = 1'b0;
                m_ptr      = 0;
                m_fs       = cyc;
                m_fire     = -1;
                m_out_id   = 0;
                for (int d = 0; d < 3; d++) m_out[d] = '0;
            end else if (m_valid && m_inflight && cyc == m_fire) begin
                for (int d = 0; d < 3; d++) m_out[d] = m_res[d];
                m_out_id   = m_tag;
                m_inflight = 1'b0;
                m_fire     = -1;
                m_ptr      = (m_tag + 1) % N;
                m_fs       = cyc;
                fired      = 1'b1;
            end

            if (m_valid) begin
                k        = cyc - m_fs;
                exp_req  = '0;
                if (!m_inflight && k >= 1 && (T == 0 || k <= T - 1)) exp_req[m_ptr] = 1'b1;
                exp_busy = m_inflight || (T != 0 && k >= T);
                for (int d = 0; d < 3; d++) begin
                    check("in_req",   64'(req_o[d]),  64'(exp_req));
                    check("out_ack",  64'(ack_o[d]),  64'(fired));
                    check("out_data", 64'(data_o[d]), 64'(m_out[d]));
                    check("out_id",   64'(id_o[d]),   64'(m_out_id));
                    check("busy",     64'(busy_o[d]), 64'(exp_busy));
                end

                if (!rst) begin
                    if (!m_inflight) begin
                        md   = mode[m_ptr];
                        take = (md == SPAM  && (T == 0 || k <= T)) ||
                               (md == READY && k >= 1 && (T == 0 || k <= T - 1)) ||
                               (md == LATE  && T != 0 && k == T);
                        if (take) begin
                            m_inflight   = 1'b1;
                            m_tag        = m_ptr;
                            m_res[0]     = opa[m_ptr] + opb[m_ptr];
                            m_res[1]     = opa[m_ptr] - opb[m_ptr];
                            m_res[2]     = opa[m_ptr] * opb[m_ptr];
                            m_send_ready = cyc + L + 1;
                            m_fire       = -1;
                        end else if (T != 0 && k == T) begin
                            m_ptr = (m_ptr + 1) % N;
                            m_fs  = cyc + 1;
                        end
                    end else if (m_fire < 0 && cyc >= m_send_ready && out_req) begin
                        m_fire = cyc + 1;
                    end
                end
            end

            for (int i = 0; i < N; i++) begin
                case (mode[i])
                    READY:   in_ack[i] = req_o[0][i];
                    LATE:    in_ack[i] = prev_req[i] && !req_o[0][i];
                    SPAM:    in_ack[i] = 1'b1;
                    default: in_ack[i] = 1'b0;
                endcase
            end
            if (in_ack[0] && mode[0] == READY) ack0_t = cyc;
            prev_req = req_o[0];
            rst_prev = rst;
        end
    end

    // ---------------- directed sequence ----------------
    int ids3 [4]  = '{2, 0, 1, 2};
    int gaps3 [4] = '{12, 14, 4, 12};

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (ack_o[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (ack_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s: no out_ack within 300 cycles", name);
        end
    endtask

    initial begin
        int t_prev, t_rel, cnt, eid;
        logic [W-1:0] got_data;
        logic [IW-1:0] got_id;

        for (int i = 0; i < N; i++) begin
            mode[i] = SILENT;
            opa[i]  = '0;
            opb[i]  = '0;
        end
        mode[0] = READY;
        opa[0]  = 32'd5;
        opb[0]  = 32'd7;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single channel
        wait_ack("single_first");
        t_prev = now_cyc();
        check("single_latency", 64'(t_prev - ack0_t), 64'd4);
        check("single_add", 64'(data_o[0]), 64'd12);
        check("single_sub", 64'(data_o[1]), 64'hFFFF_FFFE);
        check("single_mul", 64'(data_o[2]), 64'd35);
        check("single_id",  64'(id_o[0]),   64'd0);
        wait_ack("single_second");
        check("single_period", 64'(now_cyc() - t_prev), 64'd32);
        check("single_add2", 64'(data_o[0]), 64'd12);
        t_prev = now_cyc();

        // all channels ready
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            mode[i] = READY;
            opa[i]  = W'(i);
            opb[i]  = 32'd10;
        end
        for (int j = 0; j < 5; j++) begin
            wait_ack("all_ready");
            eid = (j + 1) % N;
            check("all_id",  64'(id_o[0]),   64'(eid));
            check("all_add", 64'(data_o[0]), 64'(10 + eid));
            check("all_mul", 64'(data_o[2]), 64'(10 * eid));
            check("all_gap", 64'(now_cyc() - t_prev), 64'd5);
            t_prev = now_cyc();
        end

        // late ack, stray acks, silent channel
        @(posedge clk); #1;
        mode[0] = READY;
        mode[1] = SPAM;
        mode[2] = LATE;
        mode[3] = SILENT;
        for (int j = 0; j < 4; j++) begin
            wait_ack("late");
            check("late_id",  64'(id_o[0]), 64'(ids3[j]));
            check("late_gap", 64'(now_cyc() - t_prev), 64'(gaps3[j]));
            t_prev = now_cyc();
        end

        // wrap and backpressure on channel 3, then multiply truncation on 0
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) mode[i] = READY;
        opa[3]  = 32'd3;
        opb[3]  = 32'd5;
        opa[0]  = 32'h0001_0000;
        opb[0]  = 32'h0001_0001;
        out_req = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                check("bp_ack",  64'(ack_o[1]),  64'd0);
                check("bp_busy", 64'(busy_o[1]), 64'd1);
            end
        end
        @(posedge clk); #1 out_req = 1'b1;
        cnt      = 0;
        got_data = '0;
        got_id   = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (ack_o[1]) begin
                cnt++;
                got_data = data_o[1];
                got_id   = id_o[1];
            end
        end
        check("bp_pulses", 64'(cnt), 64'd1);
        check("wrap_sub",  64'(got_data), 64'hFFFF_FFFE);
        check("wrap_id",   64'(got_id), 64'd3);

        wait_ack("mul");
        check("mul_trunc", 64'(data_o[2]), 64'h0001_0000);
        check("mul_id",    64'(id_o[2]),   64'd0);

        // reset mid-EXEC of channel 1
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_req",  64'(req_o[d]),  64'd0);
            check("rst_ack",  64'(ack_o[d]),  64'd0);
            check("rst_data", 64'(data_o[d]), 64'd0);
            check("rst_id",   64'(id_o[d]),   64'd0);
            check("rst_busy", 64'(busy_o[d]), 64'd0);
        end
        @(negedge clk);
        t_rel = now_cyc();
        check("rst_req0", 64'(req_o[0]), 64'b0001);
        wait_ack("after_reset");
        check("after_rst_id",  64'(id_o[0]),   64'd0);
        check("after_rst_add", 64'(data_o[0]), 64'h0002_0001);
        check("after_rst_lat", 64'(now_cyc() - t_rel), 64'd4);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1);
    end

endmodule

// File: doc/shared_op_scheduler.md
# shared_op_scheduler

Time-multiplexes one arithmetic operator between `num_ch` dataflow channels using the req/ack pull handshake of the async dataflow graph. The block visits input channels round-robin and pulls an operand pair from each. It computes the configured operation over a fixed latency and delivers the result, tagged with its source channel, on a single output channel. It replaces several per-edge `add`/`sub`/`mul` nodes when area matters more than throughput.

## Interface
- `data_width`, 32: operand and result width.
- `num_ch`, 4: number of input channels, 2..16.
- `id_width`, 2: width of the channel tag; must satisfy 2^`id_width` >= `num_ch`.
- `op`, "add": operation, one of "add", "sub", "mul".
- `latency`, 2: execute cycles, 1..15.
- `fetch_timeout`, 8: cycles to wait for an ack before skipping a channel; 0 = wait forever.

- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_req`, out, `num_ch`: per-channel pull request (one-hot or zero).
- `in_ack`, in, `num_ch`: per-channel one-cycle data-valid pulse.
- `in_data`, in, `num_ch`*2*`data_width`: per-channel operands.
  - Channel i occupies slice [2W(i+1)-1 : 2Wi].
  - Operand a is the low half; operand b is the high half.
- `out_req`, in, 1: downstream pull request.
- `out_ack`, out, 1: one-cycle result-valid pulse.
- `out_data`, out, `data_width`: result; held stable until the next `out_ack`.
- `out_id`, out, `id_width`: source channel of `out_data`; held with it.
- `busy`, out, 1: high in every state except FETCH.

## Operation
- State machine: FETCH, DRAIN, EXEC, SEND. Round-robin pointer `ptr` in 0..`num_ch`-1.
- Reset: state FETCH, `ptr`=0, all counters 0. All outputs 0: `in_req`, `out_ack`, `out_data`, `out_id`, `busy`.

- **FETCH:**
  - `in_req[ptr]`=1; all other `in_req` bits are 0.
  - `in_ack[ptr]`=1 → capture operands a and b, set tag=`ptr`, drop `in_req`, go EXEC.
  - `fetch_timeout`!=0 and the wait counter reaches `fetch_timeout` with no ack → drop `in_req`, go DRAIN.
  - If an ack arrives in the same cycle as the timeout, the ack wins.
- **DRAIN (exactly 1 cycle):** covers the late ack that producers issue from a registered `req`.
  - `in_ack[ptr]`=1 → capture operands and go EXEC.
  - Otherwise set `ptr`=`ptr`+1 mod `num_ch` and go FETCH.
- **EXEC:**
  - Counts `latency` cycles, then computes the result and goes SEND.
  - "add": a+b. "sub": a−b. "mul": a*b, low `data_width` bits.
  - All results wrap modulo 2^`data_width`.
- **SEND:**
  - When `out_req`=1 and `out_ack`=0 in a cycle, the next cycle has `out_ack`=1 with `out_data` and `out_id` updated.
  - In that same next cycle, `ptr` = tag+1 mod `num_ch` and state returns to FETCH.
  - A result is never dropped; SEND waits indefinitely for `out_req`.
- `in_ack` on any channel other than `ptr`, or outside FETCH/DRAIN, is ignored.
- Fairness: after serving channel k, the next channel offered is k+1. A silent channel costs `fetch_timeout`+1 cycles.
- Reset mid-operation aborts everything. Captured operands and any pending result are discarded, and the block restarts at channel 0.

## Timing
- `in_req` and `out_ack` are registered. `in_req[ptr]` rises in the first cycle after reset release.
- Ack sampled at cycle t:
  - `in_req` is 0 at t+1.
  - EXEC spans t+1 .. t+`latency`.
  - SEND is entered at t+`latency`+1.
  - With `out_req` held high, `out_ack` pulses at t+`latency`+2.
- Back-to-back: `in_req` for the next channel rises in the cycle after `out_ack`.
- Best-case throughput is one result per `latency`+3 cycles. There is at most one operation in flight.
- `out_ack` is never high for two consecutive cycles.

## Test plan
- **Single channel:** `num_ch`=4, op "add", `latency`=2. Only ch0 acks, with a=5, b=7; `out_req` held 1.
  - Required: `out_data`=12, `out_id`=0, `out_ack` at ack+4.
  - Then ch1..ch3 are each skipped after 8+1 cycles, and `in_req[0]` rises again.
- **All channels ready:** ch i supplies a=i, b=10.
  - Required: results 10, 11, 12, 13 with `out_id` 0, 1, 2, 3, in that order, repeating.
  - No channel is visited twice in a row.
- **Late ack:** ch2 acks exactly one cycle after the timeout drops `in_req[2]` (DRAIN cycle).
  - Required: operands accepted, `out_id`=2, `ptr` next = 3.
- **Wrap and backpressure:** op "sub", a=3, b=5.
  - Required: `out_data`=0xFFFFFFFE.
  - `out_req` held 0 for 20 cycles: `out_ack` stays 0, `busy` stays 1.
  - Then raise `out_req`: exactly one `out_ack` pulse.
- **Multiply truncation:** op "mul", a=0x10000, b=0x10001.
  - Required: `out_data`=0x00010000.
- **Reset mid-EXEC:** assert `rst` for one cycle mid-EXEC.
  - Required: all outputs 0 the next cycle, no `out_ack` for the aborted operation, `in_req[0]` high after release.
